// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and types for the polar/rect and atan engines.
// Angles are unsigned degrees scaled by 2^16 unless rescaled by deg_q().
package cordic_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCALE,
    S_ROTATE,
    S_DONE
  } state_t;

  localparam int unsigned K_Q16 = 39797;

  localparam int unsigned DEG_EB = 16;
  localparam logic [31:0] DEG90  = 32'd5898240;
  localparam logic [31:0] DEG180 = 32'd11796480;
  localparam logic [31:0] DEG270 = 32'd17694720;
  localparam logic [31:0] DEG360 = 32'd23592960;

  localparam logic [31:0] ATAN_DEG_Q16 [32] = '{
    32'd2949120, 32'd1740967, 32'd919879, 32'd466945,
    32'd234379,  32'd117304,  32'd58666,  32'd29335,
    32'd14668,   32'd7334,    32'd3667,   32'd1833,
    32'd917,     32'd458,     32'd229,    32'd115,
    32'd57,      32'd29,      32'd14,     32'd7,
    32'd4,       32'd2,       32'd1,      32'd0,
    32'd0,       32'd0,       32'd0,      32'd0,
    32'd0,       32'd0,       32'd0,      32'd0
  };

  // Rescale a Q16 degree constant to another fractional width.
  function automatic logic [63:0] deg_q(
    input logic [31:0] d16,
    input int unsigned eb
  );
    return 64'(d16 >> DEG_EB) << eb;
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent table: micro-rotation index to degrees<<16.
// No register stage, so a new entry is available every ROTATE cycle.
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [4:0]            idx,
  output logic [DATA_WIDTH-1:0] atan
);

  assign atan = DATA_WIDTH'(ATAN_DEG_Q16[idx]);

endmodule

// File: rtl/cordic_polar2rect.sv
// Iterative rotation-mode CORDIC: (radius, angle) to (x, y).
// One request in flight; result pulses out_valid for a single cycle.
module cordic_polar2rect
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EXPAND_BIT = 16,
  parameter int ITER       = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] radius,
  input  logic [DATA_WIDTH-1:0] angle,
  output logic                  out_valid,
  output logic                  angle_err,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic [DATA_WIDTH-1:0] y_out
);

  localparam int W  = DATA_WIDTH;
  localparam int IW = 5;

  localparam logic [IW-1:0] LAST = IW'(ITER - 1);

  localparam logic [W-1:0] D90  = W'(deg_q(DEG90, EXPAND_BIT));
  localparam logic [W-1:0] D180 = W'(deg_q(DEG180, EXPAND_BIT));
  localparam logic [W-1:0] D270 = W'(deg_q(DEG270, EXPAND_BIT));
  localparam logic [W-1:0] D360 = W'(deg_q(DEG360, EXPAND_BIT));

  state_t state_q, state_d;

  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [W-1:0] z_q, z_d;
  logic signed [W-1:0] rad_q, rad_d;
  logic [W-1:0]        ang_q, ang_d;
  logic [IW-1:0]       i_q, i_d;
  logic signed [W-1:0] xo_q, xo_d;
  logic signed [W-1:0] yo_q, yo_d;
  logic                ov_q, ov_d;
  logic                err_q, err_d;

  logic [W-1:0]          atan_i;
  logic signed [2*W-1:0] prod;
  logic signed [W-1:0]   rk;
  logic signed [W-1:0]   xs;
  logic signed [W-1:0]   ys;

  cordic_atan_lut #(
    .DATA_WIDTH(W)
  ) u_lut (
    .idx (i_q),
    .atan(atan_i)
  );

  // Pre-scale by 1/gain so the rotation chain ends at unit gain.
  assign prod = $signed({{W{rad_q[W-1]}}, rad_q})
              * $signed((2*W)'(K_Q16));
  assign rk   = W'(prod >>> 16);
  assign xs   = x_q >>> i_q;
  assign ys   = y_q >>> i_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    rad_d   = rad_q;
    ang_d   = ang_q;
    i_d     = i_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    ov_d    = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rad_d = radius;
          ang_d = angle;
          if (angle >= D360) begin
            state_d = S_DONE;
            ov_d    = 1'b1;
            err_d   = 1'b1;
            xo_d    = '0;
            yo_d    = '0;
          end else begin
            state_d = S_SCALE;
          end
        end
      end
      S_SCALE: begin
        state_d = S_ROTATE;
        i_d     = '0;
        if (ang_q >= D270) begin
          x_d = '0;
          y_d = -rk;
          z_d = ang_q - D270;
        end else if (ang_q >= D180) begin
          x_d = -rk;
          y_d = '0;
          z_d = ang_q - D180;
        end else if (ang_q >= D90) begin
          x_d = '0;
          y_d = rk;
          z_d = ang_q - D90;
        end else begin
          x_d = rk;
          y_d = '0;
          z_d = ang_q;
        end
      end
      S_ROTATE: begin
        if (!z_q[W-1]) begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_i;
        end
        i_d = i_q + 1'b1;
        if (i_q == LAST) begin
          state_d = S_DONE;
          ov_d    = 1'b1;
          err_d   = 1'b0;
          xo_d    = x_d;
          yo_d    = y_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      rad_q   <= '0;
      ang_q   <= '0;
      i_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      rad_q   <= rad_d;
      ang_q   <= ang_d;
      i_q     <= i_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = ov_q;
  assign angle_err = err_q;
  assign x_out     = xo_q;
  assign y_out     = yo_q;

endmodule

// File: tb/tb_cordic_polar2rect.sv
// Randomized bench for cordic_polar2rect against a real-valued trig model.
// A negedge monitor scoreboards every accepted request.
module tb_cordic_polar2rect;

  localparam int    LAT   = 26;
  localparam longint D1   = 65536;
  localparam real   PI    = 3.14159265358979323846;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] radius;
  logic [31:0] angle;
  logic        out_valid;
  logic        angle_err;
  logic [31:0] x_out;
  logic [31:0] y_out;

  typedef struct {
    int     cyc;
    longint r;
    longint a;
  } req_t;

  req_t exp_q[$];
  int   hs_log[$];
  int   cyc;
  int   ov_count;
  int   n_tests;
  int   n_fail;
  bit   prev_ov;

  cordic_polar2rect dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .radius   (radius),
    .angle    (angle),
    .out_valid(out_valid),
    .angle_err(angle_err),
    .x_out    (x_out),
    .y_out    (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string  tag,
    input longint got,
    input longint exp,
    input longint tol = 0
  );
    n_tests++;
    if (got > exp + tol || got < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)",
               tag, got, exp, tol);
    end
  endtask

  function automatic void model(
    input  longint r,
    input  longint a,
    output bit     err,
    output longint x,
    output longint y
  );
    real th;
    err = (a >= 360 * D1);
    x   = 0;
    y   = 0;
    if (!err) begin
      th = (real'(a) / real'(D1)) * PI / 180.0;
      x  = longint'(real'(r) * $cos(th));
      y  = longint'(real'(r) * $sin(th));
    end
  endfunction

  always @(negedge clk) begin
    req_t   e;
    bit     eerr;
    longint ex, ey;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (prev_ov) check("ready_after_ov", longint'(in_ready), 1);
      prev_ov = out_valid;
      if (out_valid) begin
        ov_count++;
        check("ov_pending", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          model(e.r, e.a, eerr, ex, ey);
          check("latency", cyc - e.cyc, eerr ? 1 : LAT);
          check("angle_err", longint'(angle_err), longint'(eerr));
          check("x_out", longint'($signed(x_out)), ex, eerr ? 0 : 16);
          check("y_out", longint'($signed(y_out)), ey, eerr ? 0 : 16);
        end
      end
      if (in_valid && in_ready) begin
        e.cyc = cyc;
        e.r   = longint'($signed(radius));
        e.a   = longint'(angle);
        exp_q.push_back(e);
        hs_log.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(
    input logic signed [31:0] r,
    input logic [31:0]        a,
    input bit                 hold
  );
    int n = 0;
    in_valid = 1'b1;
    radius   = r;
    angle    = a;
    while (!in_ready && n < 100) begin
      tick(1);
      n++;
    end
    check("accept_wait", n, 0, 99);
    tick(1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_wait", n, 0, 199);
    tick(1);
  endtask

  initial begin
    int base;
    int hs0;
    n_tests  = 0;
    n_fail   = 0;
    ov_count = 0;
    prev_ov  = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    radius   = '0;
    angle    = '0;

    tick(3);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_angle_err", longint'(angle_err), 0);
    check("rst_x", longint'(x_out), 0);
    check("rst_y", longint'(y_out), 0);
    rst_n = 1'b1;
    tick(2);

    issue(32'sd1048576, 32'd0, 1'b0);
    drain();
    check("t1_x", longint'($signed(x_out)), 1048576, 16);
    check("t1_y", longint'($signed(y_out)), 0, 16);

    issue(32'sd1048576, 32'(30 * D1), 1'b0);
    drain();
    check("t2_x", longint'($signed(x_out)), 908093, 16);
    check("t2_y", longint'($signed(y_out)), 524288, 16);

    issue(32'sd1048576, 32'(225 * D1), 1'b0);
    drain();
    check("t3_x", longint'($signed(x_out)), -741455, 16);
    check("t3_y", longint'($signed(y_out)), -741455, 16);

    issue(32'sd1048576, 32'(90 * D1), 1'b0);
    drain();
    check("t4_x", longint'($signed(x_out)), 0, 16);
    check("t4_y", longint'($signed(y_out)), 1048576, 16);

    issue(-32'sd500000, 32'(180 * D1), 1'b0);
    drain();
    issue(32'sd777777, 32'(270 * D1), 1'b0);
    drain();
    issue(32'sd1000000, 32'(360 * D1 - 1), 1'b0);
    drain();

    // Out-of-range angle: error pulse right after the handshake.
    issue(32'sd1048576, 32'(360 * D1), 1'b0);
    tick(2);
    check("t5_ready_t3", longint'(in_ready), 1);
    check("t5_err_x", longint'(x_out), 0);
    drain();

    // Reset in the middle of ROTATE aborts silently.
    base = ov_count;
    issue(32'sd1048576, 32'(45 * D1), 1'b0);
    tick(4);
    rst_n = 1'b0;
    exp_q.delete();
    tick(2);
    check("t6_rst_ov", longint'(out_valid), 0);
    check("t6_rst_x", longint'(x_out), 0);
    check("t6_rst_y", longint'(y_out), 0);
    check("t6_rst_ready", longint'(in_ready), 1);
    rst_n = 1'b1;
    tick(1);
    check("t6_ready", longint'(in_ready), 1);
    tick(30);
    check("t6_no_ov", ov_count, base);
    issue(-32'sd300000, 32'(135 * D1), 1'b0);
    drain();

    // Back-to-back with in_valid held high.
    base = ov_count;
    hs0  = hs_log.size();
    issue(32'sd1048576, 32'(10 * D1), 1'b1);
    issue(-32'sd654321, 32'(100 * D1), 1'b1);
    issue(32'sd123456, 32'(300 * D1), 1'b0);
    drain();
    check("t7_hs_count", hs_log.size() - hs0, 3);
    if (hs_log.size() - hs0 == 3) begin
      check("t7_gap1", hs_log[hs0 + 1] - hs_log[hs0], 27);
      check("t7_gap2", hs_log[hs0 + 2] - hs_log[hs0 + 1], 27);
    end
    check("t7_results", ov_count - base, 3);

    for (int k = 0; k < 16; k++) begin
      int unsigned mag;
      logic signed [31:0] r;
      logic [31:0] a;
      mag = $urandom_range(0, 1 << 20);
      r   = ($urandom % 2) ? -32'(mag) : 32'(mag);
      if ($urandom % 6 == 0)
        a = $urandom_range(360 * 65536, 400 * 65536);
      else
        a = $urandom_range(0, 360 * 65536 - 1);
      issue(r, a, 1'b0);
      tick($urandom_range(0, 3));
    end
    drain();
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
